// File: rtl/eq_run_detector_if.sv
// Handshake bundle for eq_run_detector: operand pair in, equality/run result out.
// The miss_cnt field is present only when EQ_RUN_MISS_CNT_EN is defined.
interface eq_run_detector_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic             eq;
  logic [CNT_W-1:0] run_cnt;
  logic             run_hit;
`ifdef EQ_RUN_MISS_CNT_EN
  logic [15:0]      miss_cnt;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, eq, run_cnt, run_hit, miss_cnt
  );
  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, eq, run_cnt, run_hit, miss_cnt
  );
`else
  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, eq, run_cnt, run_hit
  );
  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, eq, run_cnt, run_hit
  );
`endif
endinterface

// File: rtl/eq_run_detector.sv
// Streaming equality stage: registers (a == b) per accepted pair and tracks the run of equal pairs.
// Optional macro EQ_RUN_MISS_CNT_EN adds a saturating 16-bit count of unequal pairs (miss_cnt).
module eq_run_detector #(
  parameter int WIDTH   = 4,
  parameter int CNT_W   = 8,
  parameter int RUN_LEN = 4
) (
  input  logic              clk,
  input  logic              rst,
  eq_run_detector_if.slave  bus
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] HIT  = 2'd2;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] RUN_THR = CNT_W'(RUN_LEN);

  logic             out_valid_reg;
  logic             eq_reg;
  logic [CNT_W-1:0] run_cnt_reg;
  logic             run_hit_reg;
  logic [1:0]       state_reg;
  logic [1:0]       state_next;
  logic [CNT_W-1:0] run_cnt_next;
  logic             run_hit_next;
  logic [WIDTH-1:0] bit_eq;
  logic             pair_eq;
  logic             in_ready;
  logic             accept;
  logic             drain;

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit_eq
      assign bit_eq[gi] = ~(bus.a[gi] ^ bus.b[gi]);
    end
  endgenerate
  assign pair_eq = &bit_eq;

  // Not ready during reset so nothing is accepted into a register that is being cleared.
  assign in_ready = !rst && (!out_valid_reg || bus.out_ready);
  assign accept   = bus.in_valid && in_ready;
  assign drain    = out_valid_reg && bus.out_ready;

  always_comb begin
    run_cnt_next = '0;
    if (pair_eq) begin
      run_cnt_next = (run_cnt_reg == CNT_MAX) ? CNT_MAX : run_cnt_reg + 1'b1;
    end
    run_hit_next = (run_cnt_next >= RUN_THR);
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    state_next = pair_eq ? (run_hit_next ? HIT : RUN) : IDLE;
      RUN:     state_next = pair_eq ? (run_hit_next ? HIT : RUN) : IDLE;
      HIT:     state_next = pair_eq ? HIT : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_reg <= 1'b0;
      eq_reg        <= 1'b0;
      run_cnt_reg   <= '0;
      run_hit_reg   <= 1'b0;
      state_reg     <= IDLE;
    end else if (accept) begin
      out_valid_reg <= 1'b1;
      eq_reg        <= pair_eq;
      run_cnt_reg   <= run_cnt_next;
      run_hit_reg   <= run_hit_next;
      state_reg     <= state_next;
    end else if (drain) begin
      out_valid_reg <= 1'b0;
    end
  end

`ifdef EQ_RUN_MISS_CNT_EN
  logic [15:0] miss_cnt_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      miss_cnt_reg <= '0;
    end else if (accept && !pair_eq && miss_cnt_reg != 16'hFFFF) begin
      miss_cnt_reg <= miss_cnt_reg + 16'd1;
    end
  end
  assign bus.miss_cnt = miss_cnt_reg;
`endif

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_reg;
  assign bus.eq        = eq_reg;
  assign bus.run_cnt   = run_cnt_reg;
  // The run flag follows the FSM; HIT and run_hit_reg are kept in lockstep.
  assign bus.run_hit   = run_hit_reg && (state_reg == HIT);
endmodule

// File: tb/tb_eq_run_detector.sv
// Directed bench for eq_run_detector: default instance plus a CNT_W=3 instance for saturation.
// Miss-counter steps run only when EQ_RUN_MISS_CNT_EN is defined.
module tb_eq_run_detector;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  eq_run_detector_if #(.WIDTH(4), .CNT_W(8)) bus0 ();
  eq_run_detector_if #(.WIDTH(4), .CNT_W(3)) bus1 ();

  eq_run_detector #(.WIDTH(4), .CNT_W(8), .RUN_LEN(4)) u_dut0 (
    .clk(clk), .rst(rst), .bus(bus0.slave)
  );
  eq_run_detector #(.WIDTH(4), .CNT_W(3), .RUN_LEN(4)) u_dut1 (
    .clk(clk), .rst(rst), .bus(bus1.slave)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive0(input logic v, input logic [3:0] av, input logic [3:0] bv);
    bus0.in_valid = v;
    bus0.a        = av;
    bus0.b        = bv;
  endtask

  initial begin
    logic [3:0] pa [5];
    logic [3:0] pb [5];
    logic [7:0] exp_cnt [5];
    logic       exp_hit [5];
    logic       exp_eq  [5];
    logic [2:0] sat_cnt;

    pa = '{4'd5, 4'd5, 4'd5, 4'd5, 4'd3};
    pb = '{4'd5, 4'd5, 4'd5, 4'd5, 4'd7};
    exp_cnt = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd0};
    exp_hit = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    exp_eq  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    drive0(1'b0, 4'd0, 4'd0);
    bus0.out_ready = 1'b1;
    bus1.in_valid  = 1'b0;
    bus1.a         = 4'd0;
    bus1.b         = 4'd0;
    bus1.out_ready = 1'b1;

    // Reset then idle
    rst = 1'b1;
    step();
    step();
    check("in_ready_in_reset", 32'(bus0.in_ready), 32'd0);
    rst = 1'b0;
    step();
    check("rst_out_valid", 32'(bus0.out_valid), 32'd0);
    check("rst_eq",        32'(bus0.eq),        32'd0);
    check("rst_run_cnt",   32'(bus0.run_cnt),   32'd0);
    check("rst_run_hit",   32'(bus0.run_hit),   32'd0);
    check("rst_in_ready",  32'(bus0.in_ready),  32'd1);
    $display("txn reset: out_valid=%0b run_cnt=%0d in_ready=%0b", bus0.out_valid, bus0.run_cnt, bus0.in_ready);

    // Run to hit
    for (int i = 0; i < 5; i++) begin
      drive0(1'b1, pa[i], pb[i]);
      step();
      check("run_out_valid", 32'(bus0.out_valid), 32'd1);
      check("run_eq",        32'(bus0.eq),        32'(exp_eq[i]));
      check("run_cnt",       32'(bus0.run_cnt),   32'(exp_cnt[i]));
      check("run_hit",       32'(bus0.run_hit),   32'(exp_hit[i]));
      $display("txn run %0d: a=%0d b=%0d eq=%0b run_cnt=%0d run_hit=%0b", i, pa[i], pb[i], bus0.eq, bus0.run_cnt, bus0.run_hit);
    end

    // X operands with in_valid low must not be accepted
    drive0(1'b0, 4'bxxxx, 4'bxxxx);
    step();
    check("x_idle_out_valid", 32'(bus0.out_valid), 32'd0);
    check("x_idle_run_cnt",   32'(bus0.run_cnt),   32'd0);
    check("x_idle_eq",        32'(bus0.eq),        32'd0);
    $display("txn idle-x: out_valid=%0b run_cnt=%0d", bus0.out_valid, bus0.run_cnt);

    // Backpressure
    drive0(1'b1, 4'd9, 4'd9);
    bus0.out_ready = 1'b0;
    step();
    check("bp_first_cnt", 32'(bus0.run_cnt), 32'd1);
    check("bp_in_ready",  32'(bus0.in_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("bp_hold_in_ready",  32'(bus0.in_ready),  32'd0);
      check("bp_hold_out_valid", 32'(bus0.out_valid), 32'd1);
      check("bp_hold_eq",        32'(bus0.eq),        32'd1);
      check("bp_hold_run_cnt",   32'(bus0.run_cnt),   32'd1);
      $display("txn stall %0d: in_ready=%0b eq=%0b run_cnt=%0d", i, bus0.in_ready, bus0.eq, bus0.run_cnt);
    end
    bus0.out_ready = 1'b1;
    #1;
    check("bp_release_in_ready", 32'(bus0.in_ready), 32'd1);
    step();
    check("bp_release_run_cnt", 32'(bus0.run_cnt), 32'd2);
    $display("txn release: run_cnt=%0d", bus0.run_cnt);
    drive0(1'b0, 4'd0, 4'd0);
    step();
    check("drain_out_valid", 32'(bus0.out_valid), 32'd0);
    check("drain_keep_cnt",  32'(bus0.run_cnt),   32'd2);

    // Saturation on the CNT_W=3 instance
    bus1.in_valid = 1'b1;
    bus1.a = 4'd6;
    bus1.b = 4'd6;
    for (int i = 0; i < 10; i++) begin
      step();
      sat_cnt = (i + 1 > 7) ? 3'd7 : 3'(i + 1);
      check("sat_run_cnt", 32'(bus1.run_cnt), 32'(sat_cnt));
      check("sat_run_hit", 32'(bus1.run_hit), (i >= 3) ? 32'd1 : 32'd0);
      $display("txn sat %0d: run_cnt=%0d run_hit=%0b", i, bus1.run_cnt, bus1.run_hit);
    end
    bus1.in_valid = 1'b0;

    // Reset mid-run
    drive0(1'b1, 4'd1, 4'd2);
    step();
    check("mid_clear_cnt", 32'(bus0.run_cnt), 32'd0);
    drive0(1'b1, 4'd8, 4'd8);
    step();
    step();
    step();
    check("mid_run_cnt3", 32'(bus0.run_cnt), 32'd3);
    drive0(1'b0, 4'd0, 4'd0);
    bus0.out_ready = 1'b0;
    rst = 1'b1;
    step();
    check("mid_rst_out_valid", 32'(bus0.out_valid), 32'd0);
    check("mid_rst_run_cnt",   32'(bus0.run_cnt),   32'd0);
    check("mid_rst_in_ready",  32'(bus0.in_ready),  32'd0);
    rst = 1'b0;
    bus0.out_ready = 1'b1;
    drive0(1'b1, 4'd8, 4'd8);
    step();
    check("mid_after_run_cnt", 32'(bus0.run_cnt), 32'd1);
    $display("txn reset-mid: run_cnt=%0d", bus0.run_cnt);
    drive0(1'b0, 4'd0, 4'd0);
    step();

`ifdef EQ_RUN_MISS_CNT_EN
    begin
      logic [3:0]  ma [4];
      logic [3:0]  mb [4];
      logic [15:0] mexp [4];
      ma   = '{4'd1, 4'd4, 4'd0, 4'd15};
      mb   = '{4'd2, 4'd4, 4'd15, 4'd0};
      mexp = '{16'd1, 16'd1, 16'd2, 16'd3};
      rst = 1'b1;
      step();
      rst = 1'b0;
      step();
      check("miss_rst", 32'(bus0.miss_cnt), 32'd0);
      for (int i = 0; i < 4; i++) begin
        drive0(1'b1, ma[i], mb[i]);
        step();
        check("miss_cnt", 32'(bus0.miss_cnt), 32'(mexp[i]));
        $display("txn miss %0d: a=%0d b=%0d miss_cnt=%0d", i, ma[i], mb[i], bus0.miss_cnt);
      end
      drive0(1'b0, 4'd0, 4'd0);
      step();
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/eq_run_detector.md
Name: eq_run_detector

Overview:
- Streaming equality stage that consumes back-to-back 4-bit operand pairs under valid/ready handshake.
- Registers the per-pair equality result and tracks the length of the current run of consecutive equal pairs.
- Flags when the run reaches a programmed length.
- Sits downstream of the operand source and feeds a controller that acts on match runs, e.g. pattern lock or debounce.

Parameters:
- WIDTH, 4, operand width in bits.
- CNT_W, 8, width of the run counter.
- RUN_LEN, 4, run length at which run_hit asserts; legal range 1 to 2^CNT_W-1.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  stage can accept a pair this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- out_valid  output  1  result register holds an unconsumed result.
- out_ready  input  1  downstream accepts the result this cycle.
- eq  output  1  registered (a == b) for the held result.
- run_cnt  output  CNT_W  consecutive-equal count including the held result.
- run_hit  output  1  held result has run_cnt >= RUN_LEN.

Behaviour:
- Reset (rst=1 at a clock edge):
  - out_valid=0, eq=0, run_cnt=0, run_hit=0, state=IDLE.
  - Any held, unconsumed result is discarded.
  - in_ready is low during the reset cycle and high on the first cycle after reset.
- Handshake:
  - Accept: in_valid && in_ready. Drain: out_valid && out_ready.
  - in_ready = !out_valid || out_ready (combinational). Accept and drain in the same cycle are allowed, giving full throughput.
  - While out_valid && !out_ready: eq, run_cnt and run_hit are held stable, and in_ready=0.
  - Drain without accept: out_valid clears next cycle. eq, run_cnt, run_hit and state keep their values; only out_valid drops.
- Latency: exactly 1 cycle from accept to out_valid=1 with the corresponding result.
- On accept:
  - eq <= (a == b), full WIDTH bits compared.
  - If equal: run_cnt <= run_cnt + 1, saturating at 2^CNT_W-1 (no wrap).
  - If not equal: run_cnt <= 0.
  - run_hit <= (next run_cnt >= RUN_LEN).
- State machine (advances only on accept):
  - IDLE: run_cnt = 0. Equal pair -> RUN, or -> HIT if RUN_LEN=1. Unequal pair -> stay IDLE.
  - RUN: 0 < run_cnt < RUN_LEN. Equal pair -> stay RUN, or -> HIT when next count = RUN_LEN. Unequal pair -> IDLE.
  - HIT: run_cnt >= RUN_LEN; run_hit=1. Equal pair -> stay HIT (count saturates). Unequal pair -> IDLE.
- Boundary conditions:
  - Run continuity is counted across accepts only; idle cycles and backpressure stalls do not break a run.
  - Saturation: once run_cnt = 2^CNT_W-1, further equal pairs keep it there and keep run_hit=1.
  - X or unknown inputs are ignored when in_valid=0.

Optional Feature:
- Macro EQ_RUN_MISS_CNT_EN.
- When defined:
  - Adds output port miss_cnt (16 bits): total accepted unequal pairs since reset, saturating at 16'hFFFF.
  - Reset value 0. Updates on accept, in the same cycle as eq.
  - Held stable under backpressure like the other result fields.
- When undefined: the port and its counter are absent. All other behaviour is identical.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, then in_valid=0 -> out_valid=0, eq=0, run_cnt=0, run_hit=0, in_ready=1.
- Run to hit (RUN_LEN=4), out_ready=1:
  - Pairs (5,5),(5,5),(5,5),(5,5),(3,7) on consecutive cycles.
  - Results one cycle later: run_cnt 1,2,3,4,0; run_hit 0,0,0,1,0; eq 1,1,1,1,0.
- Backpressure:
  - Accept (9,9), then hold out_ready=0 for 3 cycles while in_valid=1 with (9,9).
  - Required: in_ready=0, eq=1, run_cnt=1 stable for 3 cycles.
  - Release out_ready -> next pair accepted; run_cnt=2 one cycle later.
- Saturation (CNT_W=3, RUN_LEN=4): 10 equal pairs -> run_cnt sequence 1..7, then stays 7; run_hit=1 from the 4th result onward.
- Reset mid-run:
  - After 3 equal pairs, assert rst with out_valid=1 and out_ready=0 -> next cycle out_valid=0, run_cnt=0.
  - The next equal pair gives run_cnt=1.
- Miss counter (EQ_RUN_MISS_CNT_EN defined): pairs (1,2),(4,4),(0,15),(15,0) -> miss_cnt 1,1,2,3.
